// File: rtl/tick_timer_pkg.sv
// Shared constants, state encodings and helpers for the tick timer arbiter.
package tick_timer_pkg;

  localparam int unsigned SYS_CLK_HZ       = 153600;
  localparam int unsigned TICK_HZ          = 10;
  localparam int unsigned TICK_DIV_DEFAULT = SYS_CLK_HZ / TICK_HZ;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_COUNT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // (a + b) mod n for a, b < n
  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-TICK_DIV prescaler; tick is the combinational wrap strobe consumed by the arbiter FSM.
module tick_prescaler
  import tick_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned     CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tick_timer_arbiter.sv
// Round-robin shared 10 Hz wait timer for NUM_REQ requesters.
// Optional pause input when TICK_TIMER_PAUSE_EN is defined.
module tick_timer_arbiter
  import tick_timer_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned DUR_W    = 8,
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DUR_W-1:0] dur,
  input  logic [NUM_REQ-1:0]       cancel,
`ifdef TICK_TIMER_PAUSE_EN
  input  logic                     pause,
`endif
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [DUR_W-1:0]         remaining,
  output logic                     tick
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic [DUR_W-1:0]   remaining_q, remaining_d;
  logic               tick_q, tick_d;

  logic [DUR_W-1:0]   dur_arr [NUM_REQ];
  logic               arb_hit_c;
  logic [IDX_W-1:0]   arb_idx_c, arb_cand_c, rr_next_c;
  logic               cancel_hit_c, pause_c, pre_clr_c, pre_en_c, pre_tick_c;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_dur
    assign dur_arr[g] = dur[g*DUR_W +: DUR_W];
  end

`ifdef TICK_TIMER_PAUSE_EN
  assign pause_c = pause;
`else
  assign pause_c = 1'b0;
`endif

  // Prescaler phase restarts at every grant and only runs while counting.
  assign pre_clr_c = (state_q != ST_COUNT);
  assign pre_en_c  = (state_q == ST_COUNT) && !pause_c;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr_c),
    .en   (pre_en_c),
    .tick (pre_tick_c)
  );

  // First pending request at or after rr_ptr, wrapping.
  always_comb begin
    arb_hit_c  = 1'b0;
    arb_idx_c  = '0;
    arb_cand_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      arb_cand_c = IDX_W'(wrap_add(32'(rr_ptr_q), i, NUM_REQ));
      if (!arb_hit_c && req[arb_cand_c]) begin
        arb_hit_c = 1'b1;
        arb_idx_c = arb_cand_c;
      end
    end
  end

  assign rr_next_c = IDX_W'(wrap_add(32'(idx_q), 1, NUM_REQ));

  // Owner can still abort during the final DONE cycle, so cancel beats a coincident last tick.
  assign cancel_hit_c = cancel[idx_q] && ((state_q == ST_COUNT) || (state_q == ST_DONE));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    done_d      = '0;
    remaining_d = remaining_q;
    tick_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (arb_hit_c) begin
          idx_d              = arb_idx_c;
          grant_d[arb_idx_c] = 1'b1;
          remaining_d        = dur_arr[arb_idx_c];
          state_d            = (dur_arr[arb_idx_c] != '0) ? ST_COUNT : ST_DONE;
        end
      end
      ST_COUNT: begin
        if (cancel_hit_c) begin
          state_d     = ST_IDLE;
          grant_d     = '0;
          remaining_d = '0;
          rr_ptr_d    = rr_next_c;
        end else if (pre_tick_c) begin
          tick_d      = 1'b1;
          remaining_d = remaining_q - DUR_W'(1);
          if (remaining_q == DUR_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d       = ST_IDLE;
        grant_d       = '0;
        rr_ptr_d      = rr_next_c;
        done_d[idx_q] = !cancel_hit_c;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (grant_d != '0) || (done_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      remaining_q <= '0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      remaining_q <= remaining_d;
      tick_q      <= tick_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign remaining = remaining_q;
  assign tick      = tick_q;

endmodule
